sm_operand_entry: RTL and testbench

SM_OPERAND_ENTRY -- requirements
Module: sm_operand_entry

---
 rtl/sm_operand_entry.sv | 156 +++++++++++++++
 tb/tb_sm_operand_entry.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_operand_entry.sv
// sm_operand_entry: two-operand sign-magnitude entry front end.
// Raw buttons (btn[0] commit, btn[1] clear) are synchronized and debounced.
// Each debounced press steps a small FSM that captures operands A and B from
// the switches and offers them with a valid/ready handshake.
// Optional build macro SM_ENTRY_NEGZERO_NORM_EN: store a captured -0 as +0.
module sm_operand_entry #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   btn,
  input  logic [N-1:0] sw,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [1:0]   sel,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_VALID = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  logic [1:0]    btn_s1, btn_s2;
  logic [N-1:0]  sw_s1, sw_s2;
  logic          primed_0, primed;
  logic [1:0]    stable, stable_q, armed, press;
  logic [CW-1:0] cnt [2];

  state_t        state, state_next;
  logic [N-1:0]  a_next, b_next;
  logic          commit, clear;

  // Captured value: verbatim, or with -0 folded to +0 when the macro is set.
  function automatic logic [N-1:0] norm(input logic [N-1:0] v);
`ifdef SM_ENTRY_NEGZERO_NORM_EN
    return (v[N-2:0] == '0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Encode the display select from a state.
  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      S_A:     return 2'b00;
      S_B:     return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Two-flop synchronizers for buttons and switches; primed marks the point
  // where the synchronizers hold post-reset samples rather than reset zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      primed_0 <= 1'b0;
      primed   <= 1'b0;
    end else begin
      // NOTE: every sequential update uses <= so all flops sample pre-edge values.
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      primed_0 <= 1'b1;
      primed   <= primed_0;
    end
  end

  // Per-button debouncer, rising-edge press detector and post-reset arming.
  // A button only becomes armed once it has been seen released, so one held
  // through reset cannot produce an event until released and pressed again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= '0;
      stable_q <= '0;
      armed    <= '0;
      press    <= '0;
      // NOTE: the small counter array is reset element by element; it is state, not a RAM.
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        stable_q[i] <= stable[i];
        press[i]    <= stable[i] & ~stable_q[i] & armed[i];
        if (btn_s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= btn_s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (primed && !stable[i] && !btn_s2[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign commit = press[0];
  assign clear  = press[1];

  // Next-state and operand capture; clear overrides everything.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    a_next     = a;
    b_next     = b;
    if (clear) begin
      state_next = S_A;
      a_next     = '0;
      b_next     = '0;
    end else begin
      case (state)
        S_A: if (commit) begin
          a_next     = norm(sw_s2);
          state_next = S_B;
        end
        S_B: if (commit) begin
          b_next     = norm(sw_s2);
          state_next = S_VALID;
        end
        // out_valid is high throughout S_VALID, so out_ready alone completes the transfer.
        S_VALID: if (out_ready) state_next = S_SHOW;
        S_SHOW:  if (commit) state_next = S_A;
        default: state_next = S_A;
      endcase
    end
  end

  // State and registered outputs; sel/out_valid are decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_A;
      a         <= '0;
      b         <= '0;
      sel       <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      a         <= a_next;
      b         <= b_next;
      sel       <= sel_of(state_next);
      out_valid <= (state_next == S_VALID);
    end
  end

endmodule

// File: tb/tb_sm_operand_entry.sv
// tb_sm_operand_entry: directed bench for sm_operand_entry (N=4, DB_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sm_operand_entry;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   btn = 2'b00;
  logic [N-1:0] sw = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] a, b;
  logic [1:0]   sel;
  logic         out_valid;

  int tests = 0;
  int failed = 0;

  sm_operand_entry #(.N(N), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn       (btn),
    .sw        (sw),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sa;
    logic [3:0] sb;
    logic [3:0] ea;
    logic [3:0] eb;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the given buttons 10 cycles, then release for 10 cycles.
  task automatic press(input logic [1:0] m);
    btn = m;
    cycles(10);
    btn = 2'b00;
    cycles(10);
  endtask

  task automatic wait_sel(input logic [1:0] want, input int bound);
    int i = 0;
    while (sel !== want && i < bound) begin
      cycles(1);
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] old_v, prev_b;
    logic       ov_before;
    int         n;

    vecs[0] = '{sa: 4'b0101, sb: 4'b1011, ea: 4'b0101, eb: 4'b1011};
`ifdef SM_ENTRY_NEGZERO_NORM_EN
    vecs[1] = '{sa: 4'b1000, sb: 4'b0111, ea: 4'b0000, eb: 4'b0111};
    vecs[2] = '{sa: 4'b1111, sb: 4'b1000, ea: 4'b1111, eb: 4'b0000};
`else
    vecs[1] = '{sa: 4'b1000, sb: 4'b0111, ea: 4'b1000, eb: 4'b0111};
    vecs[2] = '{sa: 4'b1111, sb: 4'b1000, ea: 4'b1111, eb: 4'b1000};
`endif
    vecs[3] = '{sa: 4'b0000, sb: 4'b0001, ea: 4'b0000, eb: 4'b0001};

    // Reset state
    cycles(3);
    check("reset a", a, 0);
    check("reset b", b, 0);
    check("reset sel", sel, 0);
    check("reset out_valid", out_valid, 0);
    reset_n = 1'b1;
    cycles(5);

    // Bouncing commit: toggling every cycle never settles
    sw = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      btn[0] = ~btn[0];
      cycles(1);
    end
    btn = 2'b00;
    cycles(20);
    check("bounce sel", sel, 2'b00);
    check("bounce a", a, 4'b0000);

    // First commit: latency from clean press to captured A is DB+4 edges
    old_v = a;
    btn = 2'b01;
    n = 0;
    while (a === old_v && n < 30) begin
      cycles(1);
      n++;
    end
    check("press latency", n, DB + 4);
    check("latch a", a, 4'b0101);
    check("sel after a", sel, 2'b01);
    check("no valid in S_B", out_valid, 0);
    if (n < 10) cycles(10 - n);
    btn = 2'b00;
    cycles(10);

    // Second commit: out_valid low until B is captured, high with it
    sw = 4'b1011;
    old_v = b;
    ov_before = 1'b1;
    btn = 2'b01;
    n = 0;
    while (b === old_v && n < 30) begin
      ov_before = out_valid;
      cycles(1);
      n++;
    end
    check("valid low before b", ov_before, 0);
    check("latch b", b, 4'b1011);
    check("valid with b", out_valid, 1);
    check("sel valid", sel, 2'b10);
    if (n < 10) cycles(10 - n);
    btn = 2'b00;
    cycles(10);

    // Stall in S_VALID with commits ignored
    sw = 4'b1111;
    press(2'b01);
    press(2'b01);
    cycles(10);
    check("stall valid", out_valid, 1);
    check("stall a", a, 4'b0101);
    check("stall b", b, 4'b1011);
    check("stall sel", sel, 2'b10);
    out_ready = 1'b1;
    cycles(1);
    check("handshake valid drop", out_valid, 0);
    check("show sel", sel, 2'b10);
    out_ready = 1'b0;

    // S_SHOW commit returns to S_A keeping a/b; new A overwrites only a
    press(2'b01);
    check("show->A sel", sel, 2'b00);
    check("show->A keep a", a, 4'b0101);
    check("show->A keep b", b, 4'b1011);
    sw = 4'b0011;
    press(2'b01);
    check("re-latch a", a, 4'b0011);
    check("keep old b", b, 4'b1011);
    check("re-latch sel", sel, 2'b01);

    // Commit and clear together in S_B: clear wins
    sw = 4'b0110;
    press(2'b11);
    check("clear a", a, 0);
    check("clear b", b, 0);
    check("clear sel", sel, 2'b00);
    check("clear valid", out_valid, 0);

    // Table: full A/B entry with out_ready already high on entry to S_VALID
    prev_b = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      check($sformatf("v%0d start sel", r), sel, 2'b00);
      sw = vecs[r].sa;
      press(2'b01);
      check($sformatf("v%0d a", r), a, vecs[r].ea);
      check($sformatf("v%0d b kept", r), b, prev_b);
      check($sformatf("v%0d sel B", r), sel, 2'b01);
      out_ready = 1'b1;
      sw = vecs[r].sb;
      btn = 2'b01;
      wait_sel(2'b10, 30);
      check($sformatf("v%0d sel valid", r), sel, 2'b10);
      check($sformatf("v%0d b", r), b, vecs[r].eb);
      check($sformatf("v%0d valid", r), out_valid, 1);
      cycles(1);
      check($sformatf("v%0d one-cycle hs", r), out_valid, 0);
      check($sformatf("v%0d show sel", r), sel, 2'b10);
      cycles(6);
      btn = 2'b00;
      cycles(10);
      out_ready = 1'b0;
      press(2'b01);
      check($sformatf("v%0d back to A", r), sel, 2'b00);
      check($sformatf("v%0d a retained", r), a, vecs[r].ea);
      prev_b = vecs[r].eb;
    end

    // Reset mid-handshake discards the pending transfer
    sw = 4'b0010;
    press(2'b01);
    press(2'b01);
    check("pre-reset valid", out_valid, 1);
    reset_n = 1'b0;
    cycles(2);
    check("hs reset valid", out_valid, 0);
    check("hs reset a", a, 0);
    check("hs reset b", b, 0);
    check("hs reset sel", sel, 2'b00);
    reset_n = 1'b1;
    cycles(5);

    // Reset mid-debounce with commit held through reset release
    sw = 4'b0110;
    btn = 2'b01;
    cycles(4);
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(20);
    check("held through reset sel", sel, 2'b00);
    check("held through reset a", a, 0);
    btn = 2'b00;
    cycles(15);
    check("release no event", sel, 2'b00);
    press(2'b01);
    check("press after release a", a, 4'b0110);
    check("press after release sel", sel, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
